// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier slice: default operand
// width, controller state encodings (3-bit binary) and the shift-counter
// width helper.
// Ports: none (package).
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_SHIFT = 3'd2;
    localparam state_t S_TEST  = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // One extra bit over $clog2 so the counter can hold WIDTH itself and
    // never wraps inside an operation.
    function automatic int ctr_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_control_if.sv
// ----------------------------------------------------------------------------
// mult_control_if
// Handshake bundle between the multiplier controller and its environment
// (requester plus accumulator).
//   Start : request one multiplication
//   M     : accumulator bit 0 (current multiplier LSB), registered upstream
//   Load  : accumulator load strobe (operands plus first partial product)
//   Sh    : accumulator right-shift strobe
//   Ad    : accumulator add strobe (upper half <= external sum)
//   Busy  : operation in progress
//   Done  : product valid in the accumulator
// Modports: slave = controller, master = requester/accumulator side.
// ----------------------------------------------------------------------------
interface mult_control_if;

    logic Start;
    logic M;
    logic Load;
    logic Sh;
    logic Ad;
    logic Busy;
    logic Done;

    modport slave (
        input  Start, M,
        output Load, Sh, Ad, Busy, Done
    );

    modport master (
        output Start, M,
        input  Load, Sh, Ad, Busy, Done
    );

endinterface

// File: rtl/mult_counter.sv
// ----------------------------------------------------------------------------
// mult_counter
// Shift counter for the multiplier controller with terminal-count compare.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-low; clears the count
//   Clr   : clear count to 0
//   Inc   : increment count
//   Last  : count == WIDTH-1 (the next shift is the final one)
// ----------------------------------------------------------------------------
module mult_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clr,
    input  logic Inc,
    output logic Last
);

    localparam int CW = ctr_width(WIDTH);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk) begin
        if (!Reset)
            count <= '0;
        else if (Clr)
            count <= '0;
        else if (Inc)
            count <= count + 1'b1;
    end

    assign Last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// ----------------------------------------------------------------------------
// mult_control
// Controller for a shift-and-add multiplier. Sequences Load, then WIDTH
// right shifts with an add inserted before each shift whose multiplier bit
// (seen on M) is set. Multiplier bit 0 is folded into the Load.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-low; returns to IDLE with priority
//   bus   : mult_control_if.slave (Start, M in; Load, Sh, Ad, Busy, Done out)
// ----------------------------------------------------------------------------
module mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_control_if.slave  bus
);

    state_t state;
    state_t next_state;

    logic ctr_clr;
    logic ctr_inc;
    logic ctr_last;

    mult_counter #(.WIDTH(WIDTH)) u_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (ctr_clr),
        .Inc   (ctr_inc),
        .Last  (ctr_last)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.Start) next_state = S_LOAD;
            S_LOAD:  next_state = S_SHIFT;
            S_SHIFT: next_state = ctr_last ? S_DONE : S_TEST;
            S_TEST: begin
                if (bus.M)
                    next_state = S_SHIFT;
                else if (ctr_last)
                    next_state = S_DONE;
            end
            // A held Start parks here so it cannot re-trigger.
            S_DONE:  if (!bus.Start) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode. TEST is Mealy on M: add without counting, or shift
    // and count; this is the only input-to-output path.
    always_comb begin
        bus.Load = 1'b0;
        bus.Sh   = 1'b0;
        bus.Ad   = 1'b0;
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        ctr_clr  = 1'b0;
        ctr_inc  = 1'b0;
        case (state)
            S_LOAD: begin
                bus.Load = 1'b1;
                bus.Busy = 1'b1;
                ctr_clr  = 1'b1;
            end
            S_SHIFT: begin
                bus.Sh   = 1'b1;
                bus.Busy = 1'b1;
                ctr_inc  = 1'b1;
            end
            S_TEST: begin
                bus.Busy = 1'b1;
                if (bus.M) begin
                    bus.Ad = 1'b1;
                end else begin
                    bus.Sh  = 1'b1;
                    ctr_inc = 1'b1;
                end
            end
            S_DONE:  bus.Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// ----------------------------------------------------------------------------
// tb_mult_control
// Drives mult_control (WIDTH=4) together with a behavioural accumulator and
// adder. Each scenario task checks strobe counts, Start-to-Done latency
// (2 + WIDTH + popcount(multiplier[3:1])) and the product; a monitor checks
// strobe exclusivity and Busy/Done exclusivity on every cycle.
// ----------------------------------------------------------------------------
module tb_mult_control;

    localparam int W = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    mult_control_if ifc();

    mult_control #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mplier = '0;
    logic [W-1:0] mcand  = '0;
    logic [2*W:0] acc;

    int tot_load = 0;
    int tot_sh   = 0;
    int tot_ad   = 0;
    bit mon_en   = 1'b0;

    // Accumulator: upper W+1 bits take the adder result, whole word shifts.
    assign ifc.M = acc[0];

    always @(posedge Clk) begin
        if (!Reset)
            acc <= '0;
        else if (ifc.Load)
            acc <= {(mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}}), mplier};
        else if (ifc.Ad)
            acc[2*W:W] <= acc[2*W:W] + {1'b0, mcand};
        else if (ifc.Sh)
            acc <= acc >> 1;
    end

    // Per-cycle strobe tally and exclusivity checks
    always @(negedge Clk) begin
        tot_load += int'(ifc.Load);
        tot_sh   += int'(ifc.Sh);
        tot_ad   += int'(ifc.Ad);
        if (mon_en) begin
            checks++;
            if ((int'(ifc.Load) + int'(ifc.Sh) + int'(ifc.Ad)) > 1 ||
                (ifc.Busy && ifc.Done)) begin
                failures++;
                $display("FAIL exclusive t=%0t Load=%b Sh=%b Ad=%b Busy=%b Done=%b",
                         $time, ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done);
            end
        end
    end

    // One operation: Start presented before the sampling edge, latency counted
    // in rising edges from that edge (inclusive) to the one raising Done.
    task automatic run_op(input logic [W-1:0] mp, input logic [W-1:0] mc,
                          input bit hold, input bit poke,
                          input int exp_prod, input int exp_ad,
                          input int exp_lat, input string name);
        int lat;
        int l0, s0, a0;
        bit got;
        @(negedge Clk);
        mplier    = mp;
        mcand     = mc;
        ifc.Start = 1'b1;
        @(posedge Clk);
        l0  = tot_load;
        s0  = tot_sh;
        a0  = tot_ad;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!hold) ifc.Start = (poke && i == 2);
            if (ifc.Done) begin
                got = 1'b1;
                break;
            end
            @(posedge Clk);
            lat++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout Done never rose within 40 cycles", name);
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (tot_load - l0 !== 1) begin
            failures++;
            $display("FAIL %s_load_count got=%0d exp=1", name, tot_load - l0);
        end
        checks++;
        if (tot_sh - s0 !== W) begin
            failures++;
            $display("FAIL %s_sh_count got=%0d exp=%0d", name, tot_sh - s0, W);
        end
        checks++;
        if (tot_ad - a0 !== exp_ad) begin
            failures++;
            $display("FAIL %s_ad_count got=%0d exp=%0d", name, tot_ad - a0, exp_ad);
        end
        checks++;
        if (int'(acc[2*W-1:0]) !== exp_prod) begin
            failures++;
            $display("FAIL %s_product got=%0d exp=%0d", name, acc[2*W-1:0], exp_prod);
        end
    endtask

    task automatic test_reset();
        ifc.Start = 1'b1;
        Reset     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            mon_en = 1'b1;
            @(negedge Clk);
            checks++;
            if ({ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%b exp=00000", i,
                         {ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done});
            end
        end
        ifc.Start = 1'b0;
        Reset     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done} !== 5'b0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%b exp=00000", i,
                         {ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done});
            end
        end
    endtask

    task automatic test_basic();
        run_op(4'b1011, 4'b1101, 1'b0, 1'b0, 143, 2, 8, "basic");
    endtask

    task automatic test_zero_multiplier();
        run_op(4'b0000, 4'b1111, 1'b0, 1'b0, 0, 0, 6, "zero");
    endtask

    task automatic test_all_ones();
        run_op(4'b1111, 4'b1111, 1'b0, 1'b0, 225, 3, 9, "ones");
    endtask

    task automatic test_mid_reset();
        int l0;
        @(negedge Clk);
        mplier    = 4'b1111;
        mcand     = 4'b1111;
        ifc.Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        ifc.Start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (ifc.Busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before got=%b exp=1", ifc.Busy);
        end
        Reset = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b exp=00000",
                     {ifc.Load, ifc.Sh, ifc.Ad, ifc.Busy, ifc.Done});
        end
        Reset = 1'b1;
        l0    = tot_load + tot_sh + tot_ad;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ((tot_load + tot_sh + tot_ad - l0) !== 0 || ifc.Busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abandon strobes=%0d busy=%b exp strobes=0 busy=0",
                     tot_load + tot_sh + tot_ad - l0, ifc.Busy);
        end
        run_op(4'b0010, 4'b0011, 1'b0, 1'b0, 6, 1, 7, "after_rst");
    endtask

    task automatic test_held_start();
        int l0;
        run_op(4'b0101, 4'b0011, 1'b1, 1'b0, 15, 1, 7, "held");
        l0 = tot_load;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if (ifc.Done !== 1'b1 || ifc.Load !== 1'b0 || ifc.Busy !== 1'b0) begin
                failures++;
                $display("FAIL held_done cycle=%0d Done=%b Load=%b Busy=%b exp 1/0/0",
                         i, ifc.Done, ifc.Load, ifc.Busy);
            end
        end
        ifc.Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (ifc.Done !== 1'b0 || ifc.Busy !== 1'b0 || tot_load !== l0) begin
            failures++;
            $display("FAIL held_release Done=%b Busy=%b loads=%0d exp 0/0/0",
                     ifc.Done, ifc.Busy, tot_load - l0);
        end
    endtask

    task automatic test_start_while_busy();
        int l0;
        run_op(4'b1001, 4'b0111, 1'b0, 1'b1, 63, 1, 7, "poke");
        l0 = tot_load;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (ifc.Busy !== 1'b0 || ifc.Done !== 1'b0 || tot_load !== l0) begin
            failures++;
            $display("FAIL poke_idle Busy=%b Done=%b loads=%0d exp 0/0/0",
                     ifc.Busy, ifc.Done, tot_load - l0);
        end
    endtask

    initial begin
        ifc.Start = 1'b0;
        test_reset();
        test_basic();
        test_zero_multiplier();
        test_all_ones();
        test_mid_reset();
        test_held_start();
        test_start_while_busy();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
